// File: rtl/lutram_capture_ctrl.sv
// Capture controller for an external single-port LUT RAM ring buffer: records strobed
// samples until a trigger plus a post-trigger count, then streams the whole buffer out oldest-first.
module lutram_capture_ctrl #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             arm_i,
  input  logic             stb_i,
  input  logic [WIDTH-1:0] smpl_i,
  input  logic             trg_i,
  input  logic [DEPTH-1:0] delay_i,
  output logic             mem_en_o,
  output logic             mem_we_o,
  output logic [DEPTH-1:0] mem_addr_o,
  output logic [WIDTH-1:0] mem_d_o,
  input  logic [WIDTH-1:0] mem_q_i,
  output logic [WIDTH-1:0] tx_data_o,
  output logic             tx_valid_o,
  input  logic             tx_ready_i,
  output logic             busy_o,
  output logic             done_o
);

  localparam logic [DEPTH-1:0] PTR_ONE = DEPTH'(1);
  localparam logic [DEPTH:0]   REM_ONE = (DEPTH+1)'(1);
  localparam logic [DEPTH:0]   N_WORDS = {1'b1, {DEPTH{1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ARMED    = 3'd1,
    S_POST     = 3'd2,
    S_RD_ISSUE = 3'd3,
    S_RD_WAIT  = 3'd4,
    S_RD_HOLD  = 3'd5
  } state_e;

  state_e           state_q, state_d;
  logic [DEPTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH-1:0] cnt_q, cnt_d;
  logic [DEPTH:0]   rem_q, rem_d;
  logic [WIDTH-1:0] tx_data_q, tx_data_d;
  logic             tx_valid_q, tx_valid_d;
  logic             done_q, done_d;

  // Next-state, pointer/counter updates and memory port drive.
  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    cnt_d      = cnt_q;
    rem_d      = rem_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    done_d     = 1'b0;
    mem_en_o   = 1'b0;
    mem_we_o   = 1'b0;
    mem_addr_o = '0;
    mem_d_o    = '0;

    case (state_q)
      S_IDLE: begin
        if (arm_i) begin
          state_d  = S_ARMED;
          wr_ptr_d = '0;
        end else begin
          state_d  = S_IDLE;
        end
      end

      S_ARMED: begin
        if (stb_i) begin
          mem_en_o   = 1'b1;
          mem_we_o   = 1'b1;
          mem_addr_o = wr_ptr_q;
          mem_d_o    = smpl_i;
          wr_ptr_d   = wr_ptr_q + PTR_ONE;
          if (trg_i && (delay_i == '0)) begin
            // Readout starts at the slot after the last write: the oldest word.
            state_d  = S_RD_ISSUE;
            rd_ptr_d = wr_ptr_q + PTR_ONE;
            rem_d    = N_WORDS;
          end else if (trg_i) begin
            state_d  = S_POST;
            cnt_d    = delay_i;
          end else begin
            state_d  = S_ARMED;
          end
        end else begin
          state_d = S_ARMED;
        end
      end

      S_POST: begin
        if (stb_i) begin
          mem_en_o   = 1'b1;
          mem_we_o   = 1'b1;
          mem_addr_o = wr_ptr_q;
          mem_d_o    = smpl_i;
          wr_ptr_d   = wr_ptr_q + PTR_ONE;
          cnt_d      = cnt_q - PTR_ONE;
          if (cnt_q == PTR_ONE) begin
            state_d  = S_RD_ISSUE;
            rd_ptr_d = wr_ptr_q + PTR_ONE;
            rem_d    = N_WORDS;
          end else begin
            state_d  = S_POST;
          end
        end else begin
          state_d = S_POST;
        end
      end

      S_RD_ISSUE: begin
        mem_en_o   = 1'b1;
        mem_addr_o = rd_ptr_q;
        state_d    = S_RD_WAIT;
      end

      S_RD_WAIT: begin
        tx_data_d  = mem_q_i;
        tx_valid_d = 1'b1;
        state_d    = S_RD_HOLD;
      end

      S_RD_HOLD: begin
        if (tx_ready_i) begin
          tx_valid_d = 1'b0;
          rd_ptr_d   = rd_ptr_q + PTR_ONE;
          rem_d      = rem_q - REM_ONE;
          if (rem_q == REM_ONE) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = S_RD_ISSUE;
          end
        end else begin
          state_d = S_RD_HOLD;
        end
      end

      default: begin
        state_d    = S_IDLE;
        tx_valid_d = 1'b0;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      rem_q      <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      rem_q      <= rem_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      done_q     <= done_d;
    end
  end

  assign tx_data_o  = tx_data_q;
  assign tx_valid_o = tx_valid_q;
  assign done_o     = done_q;
  assign busy_o     = (state_q != S_IDLE);

endmodule

// File: doc/lutram_capture_ctrl.md
LUTRAM_CAPTURE_CTRL -- requirements
Module: lutram_capture_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 32, sample/data word width in bits.
REQ-002 SHALL have parameter DEPTH, default 4, address width; buffer holds N = 2^DEPTH words.
REQ-003 SHALL have port clk_i  input  1  system clock; single clock domain, all logic on rising edge.
REQ-004 SHALL have port rst_i  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port arm_i  input  1  start capture; honoured in IDLE only.
REQ-006 SHALL have port stb_i  input  1  sample strobe; smpl_i valid this cycle.
REQ-007 SHALL have port smpl_i  input  WIDTH  sample data.
REQ-008 SHALL have port trg_i  input  1  trigger; qualified by stb_i.
REQ-009 SHALL have port delay_i  input  DEPTH  post-trigger sample count; latched at the trigger.
REQ-010 SHALL have port mem_en_o  output  1  memory enable.
REQ-011 SHALL have port mem_we_o  output  1  memory write enable.
REQ-012 SHALL have port mem_addr_o  output  DEPTH  memory address.
REQ-013 SHALL have port mem_d_o  output  WIDTH  memory write data.
REQ-014 SHALL have port mem_q_i  input  WIDTH  memory read data, valid one cycle after a read (mem_en_o=1, mem_we_o=0).
REQ-015 SHALL have port tx_data_o  output  WIDTH  readout word.
REQ-016 SHALL have port tx_valid_o  output  1  readout word valid.
REQ-017 SHALL have port tx_ready_i  input  1  downstream accepts the word.
REQ-018 SHALL have port busy_o  output  1  high in any state other than IDLE.
REQ-019 SHALL have port done_o  output  1  single-cycle pulse when readout completes.

Function
REQ-020 SHALL implement states IDLE, ARMED, POST, RD_ISSUE, RD_WAIT, RD_HOLD.
REQ-021 IDLE: arm_i=1 SHALL move to ARMED and clear wr_ptr to 0; other inputs ignored.
REQ-022 ARMED/POST: each cycle with stb_i=1 SHALL drive mem_en_o=1, mem_we_o=1, mem_addr_o=wr_ptr, mem_d_o=smpl_i, and increment wr_ptr modulo N (N-1 wraps to 0).
REQ-023 ARMED: stb_i=1 and trg_i=1 SHALL write the trigger sample, then move to POST with counter=delay_i, or directly to RD_ISSUE if delay_i=0; trg_i without stb_i SHALL be ignored.
REQ-024 POST: each stb_i write SHALL decrement the counter; the write made with counter=1 SHALL be the last, and the next state SHALL be RD_ISSUE; trg_i SHALL be ignored in POST.
REQ-025 On entering RD_ISSUE from capture, rd_ptr SHALL equal wr_ptr (oldest word first) and the words-remaining count SHALL be N.
REQ-026 RD_ISSUE SHALL drive mem_en_o=1, mem_we_o=0, mem_addr_o=rd_ptr for exactly one cycle and go to RD_WAIT.
REQ-027 RD_WAIT SHALL register mem_q_i into tx_data_o, assert tx_valid_o, and go to RD_HOLD.
REQ-028 RD_HOLD SHALL hold tx_data_o and tx_valid_o=1 stable until tx_ready_i=1; on acceptance it SHALL clear tx_valid_o, increment rd_ptr modulo N, decrement remaining, and go to RD_ISSUE, or to IDLE with done_o=1 for one cycle if this was the N-th word.
REQ-029 mem_en_o and mem_we_o SHALL be 0 in every cycle not covered by REQ-022/REQ-026; stb_i, trg_i, and arm_i SHALL be ignored during readout.
REQ-030 Readout throughput SHALL be one word per 3 cycles with tx_ready_i held at 1; first tx_valid_o SHALL rise 2 cycles after entering RD_ISSUE.
REQ-031 Words not written since arm (trigger before N samples) SHALL still be read out, with unspecified content; the count always SHALL be N.

Reset
REQ-032 rst_i=1 SHALL, on the next edge, force IDLE and zero wr_ptr, rd_ptr, counters, tx_data_o, tx_valid_o, done_o, busy_o, and mem_* outputs; it overrides all other inputs.
REQ-033 Reset asserted mid-capture or mid-readout SHALL abandon the operation without a done_o pulse; buffer contents are not cleared.

Verification (WIDTH=32, DEPTH=4, N=16)
REQ-034 Arm, strobe samples 0..19, trg_i on sample 10, delay_i=5 -> last write is sample 15 at addr 15; readout yields 0x0..0xF in order, then a done_o pulse.
REQ-035 Arm, strobe samples 0..29, trg_i on sample 24, delay_i=3 -> wr_ptr wraps; readout starts at addr 12 and yields 12..27.
REQ-036 Trigger with delay_i=0 on sample 7 (after 0..7) -> RD_ISSUE the next cycle; the first word read is from addr 8.
REQ-037 trg_i=1 with stb_i=0 in ARMED -> no state change; arm_i pulsed during POST/readout -> no effect.
REQ-038 Readout with tx_ready_i low for 5 cycles on word 3 -> tx_data_o stable and tx_valid_o high throughout; no mem read issued; resumes in order.
REQ-039 rst_i asserted during RD_HOLD -> the next cycle shows IDLE, tx_valid_o=0, busy_o=0, and no done_o.
